// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared memop codes, stall levels, bus widths and lane helpers for the MEM stage
//
// Purpose: constants and small pure functions used by mem_stage and its
// load alignment sub-module. No ports.

package mem_stage_pkg;

  // Memory operation codes carried in ex_memop.
  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LBU  = 4'd2,
    MEM_LH   = 4'd3,
    MEM_LHU  = 4'd4,
    MEM_LW   = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } memop_e;

  // Pipeline stall levels.
  localparam logic StallYes = 1'b1;
  localparam logic StallNo  = 1'b0;

  // Data bus geometry.
  localparam int BUS_AW = 32;
  localparam int BUS_DW = 32;
  localparam int BUS_SW = BUS_DW / 8;

  // Handshake FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_load(input memop_e op);
    return (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_LH) ||
           (op == MEM_LHU) || (op == MEM_LW);
  endfunction

  function automatic logic is_store(input memop_e op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes never misalign.
  function automatic logic is_misaligned(input memop_e op, input logic [1:0] a);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: return a[0];
      MEM_LW, MEM_SW:          return a != 2'b00;
      default:                 return 1'b0;
    endcase
  endfunction

  // Byte enables, bit i covers data bits 8i+7:8i (little-endian lanes).
  function automatic logic [BUS_SW-1:0] lane_sel(input memop_e op, input logic [1:0] a);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: return 4'b0001 << a;
      MEM_LH, MEM_LHU, MEM_SH: return a[1] ? 4'b1100 : 4'b0011;
      MEM_LW, MEM_SW:          return 4'b1111;
      default:                 return 4'b0000;
    endcase
  endfunction

  // Replicate the store operand across all lanes so byte enables alone pick the target.
  function automatic logic [BUS_DW-1:0] store_lanes(input memop_e op, input logic [BUS_DW-1:0] d);
    case (op)
      MEM_SB:  return {4{d[7:0]}};
      MEM_SH:  return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// rtl/mem_stage_load_align.sv - picks the addressed lane of a read word and sign/zero-extends it
//
// Purpose: combinational load data alignment.
// Ports:
//   rdata_i  in  32  captured bus read word
//   addr_i   in  2   low address bits selecting the lane
//   memop_i  in  4   load op (LB/LBU/LH/LHU/LW)
//   result_o out 32  extended load result

module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [BUS_DW-1:0] rdata_i,
  input  logic [1:0]        addr_i,
  input  memop_e            memop_i,
  output logic [BUS_DW-1:0] result_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = 8'h00;
    case (addr_i)
      2'd0: byte_lane = rdata_i[7:0];
      2'd1: byte_lane = rdata_i[15:8];
      2'd2: byte_lane = rdata_i[23:16];
      2'd3: byte_lane = rdata_i[31:24];
      default: byte_lane = 8'h00;
    endcase
    half_lane = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    result_o = rdata_i;
    case (memop_i)
      MEM_LB:  result_o = {{24{byte_lane[7]}}, byte_lane};
      MEM_LBU: result_o = {24'h000000, byte_lane};
      MEM_LH:  result_o = {{16{half_lane[15]}}, half_lane};
      MEM_LHU: result_o = {16'h0000, half_lane};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline MEM stage: data bus handshake FSM, load alignment and writeback forwarding
//
// Purpose: runs one data-memory access per memop, stalling the pipeline until
// the bus acknowledges or the access times out, then hands the writeback
// triple to mem_wb.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   stall_i                   pipeline stall for this stage (StallYes/StallNo)
//   ex_wdata_i/waddr_i/we_i   EX result, destination register, write enable
//   ex_memop_i                memory op code
//   ex_maddr_i, ex_sdata_i    effective address, store data
//   mem_wdata_o/waddr_o/we_o  writeback triple to mem_wb
//   stall_req_o               pipeline stall request
//   bus_req_o/we_o/addr_o/sel_o/wdata_o  registered bus request fields
//   bus_rdata_i, bus_ack_i    read data and one-cycle completion
//   align_err_o               misaligned access (combinational)
//   bus_err_o                 timeout abort indication

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic [31:0]       ex_wdata_i,
  input  logic [4:0]        ex_waddr_i,
  input  logic              ex_we_i,
  input  logic [3:0]        ex_memop_i,
  input  logic [31:0]       ex_maddr_i,
  input  logic [31:0]       ex_sdata_i,
  output logic [31:0]       mem_wdata_o,
  output logic [4:0]        mem_waddr_o,
  output logic              mem_we_o,
  output logic              stall_req_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [BUS_AW-1:0] bus_addr_o,
  output logic [BUS_SW-1:0] bus_sel_o,
  output logic [BUS_DW-1:0] bus_wdata_o,
  input  logic [BUS_DW-1:0] bus_rdata_i,
  input  logic              bus_ack_i,
  output logic              align_err_o,
  output logic              bus_err_o
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [BUS_AW-1:0] bus_addr_q, bus_addr_d;
  logic [BUS_SW-1:0] bus_sel_q, bus_sel_d;
  logic [BUS_DW-1:0] bus_wdata_q, bus_wdata_d;
  logic [BUS_DW-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  memop_e      op;
  logic        op_load;
  logic        op_store;
  logic        op_mem;
  logic        op_misaligned;
  logic [31:0] load_result;

  assign op            = memop_e'(ex_memop_i);
  assign op_load       = is_load(op);
  assign op_store      = is_store(op);
  assign op_mem        = op_load | op_store;
  assign op_misaligned = is_misaligned(op, ex_maddr_i[1:0]);

  mem_stage_load_align u_load_align (
    .rdata_i  (rdata_q),
    .addr_i   (ex_maddr_i[1:0]),
    .memop_i  (op),
    .result_o (load_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_sel_q   <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_sel_q   <= bus_sel_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // Next-state and registered bus fields.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_sel_d   = bus_sel_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    case (state_q)
      ST_IDLE: begin
        if (op_mem && !op_misaligned) begin
          bus_req_d   = 1'b1;
          bus_we_d    = op_store;
          bus_addr_d  = {ex_maddr_i[31:2], 2'b00};
          bus_sel_d   = lane_sel(op, ex_maddr_i[1:0]);
          bus_wdata_d = store_lanes(op, ex_sdata_i);
          cnt_d       = '0;
          err_d       = 1'b0;
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        // Ack is tested first so it wins over a simultaneous timeout.
        if (bus_ack_i) begin
          bus_req_d = 1'b0;
          rdata_d   = bus_rdata_i;
          state_d   = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          bus_req_d = 1'b0;
          err_d     = 1'b1;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        if (stall_i == StallNo) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Combinational outputs, forced to zero while reset is held.
  always_comb begin
    mem_wdata_o = '0;
    mem_waddr_o = '0;
    mem_we_o    = 1'b0;
    stall_req_o = 1'b0;
    align_err_o = 1'b0;
    bus_err_o   = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          mem_wdata_o = ex_wdata_i;
          mem_waddr_o = ex_waddr_i;
          if (!op_mem) begin
            mem_we_o = ex_we_i;
          end else if (op_misaligned) begin
            align_err_o = 1'b1;
          end else begin
            stall_req_o = 1'b1;
          end
        end
        ST_REQ: begin
          stall_req_o = 1'b1;
          mem_waddr_o = ex_waddr_i;
        end
        ST_DONE: begin
          mem_wdata_o = op_load ? load_result : ex_wdata_i;
          mem_waddr_o = ex_waddr_i;
          mem_we_o    = ex_we_i & ~err_q;
          bus_err_o   = err_q;
        end
        default: begin
          mem_we_o = 1'b0;
        end
      endcase
    end
  end

  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_sel_o   = bus_sel_q;
  assign bus_wdata_o = bus_wdata_q;

endmodule
